control_sequencer: RTL and testbench

//  Multi-cycle fetch/execute sequencer for the 16-bit processor core. Drives the PC into the

---
 rtl/control_sequencer_pkg.sv | 45 ++++
 rtl/control_sequencer_if.sv | 35 +++
 rtl/control_sequencer_pc_next_unit.sv | 35 +++
 rtl/control_sequencer.sv | 168 ++++++++++++++++
 tb/tb_control_sequencer.sv | 318 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/control_sequencer_pkg.sv
// control_sequencer_pkg
//   Shared definitions for the fetch/execute sequencer: instruction field
//   widths, opcode encodings, write-back select codes, FSM state encoding,
//   next-PC selector encoding and the immediate sign-extension helper.
package control_sequencer_pkg;

    localparam int INSTR_W = 16;
    localparam int REG_W   = 3;
    localparam int IMM_W   = 10;

    // Opcodes live in ir[15:13]
    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_UND  = 3'b010;
    localparam logic [2:0] OP_HALT = 3'b011;
    localparam logic [2:0] OP_OUT  = 3'b100;
    localparam logic [2:0] OP_LDI  = 3'b101;
    localparam logic [2:0] OP_BNE  = 3'b110;
    localparam logic [2:0] OP_JMP  = 3'b111;

    // Register-file write-back source
    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_IMM = 2'b01;
    localparam logic [1:0] WB_RS  = 2'b10;

    typedef enum logic [1:0] {
        ST_FETCH    = 2'b00,
        ST_EXEC     = 2'b01,
        ST_OUT_WAIT = 2'b10,
        ST_HALT     = 2'b11
    } state_t;

    typedef enum logic [1:0] {
        PC_HOLD    = 2'b00,
        PC_INC     = 2'b01,
        PC_INC_IMM = 2'b10,
        PC_ADD_IMM = 2'b11
    } pc_sel_t;

    // Sign-extend the 10-bit immediate field to a full instruction word.
    function automatic logic [INSTR_W-1:0] sign_ext_imm(input logic [IMM_W-1:0] field);
        return {{(INSTR_W-IMM_W){field[IMM_W-1]}}, field};
    endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// control_sequencer_if
//   Bundle of all non-clock signals between the sequencer and its
//   environment (instruction memory, register file/ALU, OUT consumer).
//   master : sequencer side (drives pc, decode fields, strobes, out_valid, halted)
//   slave  : environment side (drives run, instruction, reg_zero, out_ready)
interface control_sequencer_if
    import control_sequencer_pkg::*;
#(
    parameter int PC_W = 16
);
    logic               run;
    logic [INSTR_W-1:0] instruction;
    logic               reg_zero;
    logic [PC_W-1:0]    pc;
    logic [REG_W-1:0]   rd_sel;
    logic [REG_W-1:0]   rs_sel;
    logic [INSTR_W-1:0] imm;
    logic               alu_op;
    logic [1:0]         wb_sel;
    logic               reg_we;
    logic               out_valid;
    logic               out_ready;
    logic               halted;

    modport master (
        input  run, instruction, reg_zero, out_ready,
        output pc, rd_sel, rs_sel, imm, alu_op, wb_sel, reg_we, out_valid, halted
    );

    modport slave (
        output run, instruction, reg_zero, out_ready,
        input  pc, rd_sel, rs_sel, imm, alu_op, wb_sel, reg_we, out_valid, halted
    );

endinterface

// File: rtl/control_sequencer_pc_next_unit.sv
// pc_next_unit
//   Combinational next-PC selection. All arithmetic wraps modulo 2^PC_W.
//   pc      : current PC
//   imm     : sign-extended immediate, already sized to PC_W
//   sel     : HOLD (pc), INC (pc+1), INC_IMM (pc+1+imm), ADD_IMM (pc+imm)
//   pc_next : selected next PC
module pc_next_unit
    import control_sequencer_pkg::*;
#(
    parameter int PC_W = 16
) (
    input  logic                   [PC_W-1:0] pc,
    input  logic signed            [PC_W-1:0] imm,
    input  pc_sel_t                           sel,
    output logic                   [PC_W-1:0] pc_next
);

    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] imm_u;

    assign pc_inc = pc + PC_W'(1);
    assign imm_u  = $unsigned(imm);

    always_comb begin
        pc_next = pc;
        case (sel)
            PC_HOLD:    pc_next = pc;
            PC_INC:     pc_next = pc_inc;
            PC_INC_IMM: pc_next = pc_inc + imm_u;
            PC_ADD_IMM: pc_next = pc + imm_u;
            default:    pc_next = pc;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// control_sequencer
//   Two-cycle fetch/execute sequencer for the 16-bit core. Presents pc to a
//   combinational instruction memory, latches the word in FETCH, decodes it
//   in EXEC and issues single-cycle register-file/ALU strobes. An OUT
//   instruction parks in OUT_WAIT until the consumer accepts; halt parks in
//   HALT until reset.
//   clk   : rising-edge clock
//   reset : synchronous, active-high
//   bus   : master modport of control_sequencer_if
//           in : run, instruction, reg_zero, out_ready
//           out: pc, rd_sel, rs_sel, imm, alu_op, wb_sel, reg_we, out_valid, halted
module control_sequencer
    import control_sequencer_pkg::*;
#(
    parameter int              PC_W     = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    control_sequencer_if.master   bus
);

    state_t                    state_q, state_d;
    logic [INSTR_W-1:0]        ir_q, ir_d;
    logic [PC_W-1:0]           pc_q, pc_d;
    logic                      out_valid_q, out_valid_d;
    logic                      halted_q, halted_d;

    logic [2:0]                opcode;
    logic [REG_W-1:0]          rd;
    logic [REG_W-1:0]          rs;
    logic [INSTR_W-1:0]        imm;
    logic signed [PC_W-1:0]    imm_pc;
    pc_sel_t                   pc_sel;
    logic                      reg_we_c;
    logic                      alu_op_c;
    logic [1:0]                wb_sel_c;

    // Decode fields come straight from ir, so they stay stable from EXEC
    // through OUT_WAIT without extra registers.
    assign opcode = ir_q[15:13];
    assign rd     = ir_q[12:10];
    assign rs     = ir_q[9:7];
    assign imm    = sign_ext_imm(ir_q[IMM_W-1:0]);
    assign imm_pc = PC_W'($signed(imm));

    pc_next_unit #(
        .PC_W (PC_W)
    ) u_pc_next (
        .pc      (pc_q),
        .imm     (imm_pc),
        .sel     (pc_sel),
        .pc_next (pc_d)
    );

    always_comb begin
        state_d     = state_q;
        ir_d        = ir_q;
        out_valid_d = out_valid_q;
        halted_d    = halted_q;
        pc_sel      = PC_HOLD;
        reg_we_c    = 1'b0;
        alu_op_c    = 1'b0;
        wb_sel_c    = WB_ALU;

        case (state_q)
            ST_FETCH: begin
                if (bus.run) begin
                    ir_d    = bus.instruction;
                    state_d = ST_EXEC;
                end
            end

            ST_EXEC: begin
                state_d = ST_FETCH;
                case (opcode)
                    OP_ADD: begin
                        reg_we_c = 1'b1;
                        pc_sel   = PC_INC;
                    end
                    OP_SUB: begin
                        reg_we_c = 1'b1;
                        alu_op_c = 1'b1;
                        pc_sel   = PC_INC;
                    end
                    OP_UND: begin
                        pc_sel = PC_INC;
                    end
                    OP_HALT: begin
                        state_d  = ST_HALT;
                        halted_d = 1'b1;
                    end
                    OP_OUT: begin
                        // pc advances only when the transfer completes
                        out_valid_d = 1'b1;
                        state_d     = ST_OUT_WAIT;
                    end
                    OP_LDI: begin
                        reg_we_c = 1'b1;
                        wb_sel_c = WB_IMM;
                        pc_sel   = PC_INC;
                    end
                    OP_BNE: begin
                        // Branch is taken when the tested register is zero
                        pc_sel = bus.reg_zero ? PC_INC_IMM : PC_INC;
                    end
                    OP_JMP: begin
                        // rd = 0 selects jmp; any other rd turns it into a move
                        if (rd == '0) begin
                            pc_sel = PC_ADD_IMM;
                        end else begin
                            reg_we_c = 1'b1;
                            wb_sel_c = WB_RS;
                            pc_sel   = PC_INC;
                        end
                    end
                    default: begin
                        pc_sel = PC_INC;
                    end
                endcase
            end

            ST_OUT_WAIT: begin
                if (out_valid_q && bus.out_ready) begin
                    out_valid_d = 1'b0;
                    pc_sel      = PC_INC;
                    state_d     = ST_FETCH;
                end
            end

            ST_HALT: begin
                // absorbing; only reset leaves
            end

            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_FETCH;
            ir_q        <= '0;
            pc_q        <= RESET_PC;
            out_valid_q <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            ir_q        <= ir_d;
            pc_q        <= pc_d;
            out_valid_q <= out_valid_d;
            halted_q    <= halted_d;
        end
    end

    assign bus.pc        = pc_q;
    assign bus.rd_sel    = rd;
    assign bus.rs_sel    = rs;
    assign bus.imm       = imm;
    assign bus.alu_op    = alu_op_c;
    assign bus.wb_sel    = wb_sel_c;
    // A reset landing on the EXEC cycle must not commit the write.
    assign bus.reg_we    = reg_we_c & ~reset;
    assign bus.out_valid = out_valid_q;
    assign bus.halted    = halted_q;

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer
//   Self-checking bench for control_sequencer. Models instruction memory and
//   a small register file around the DUT, and keeps an instruction-level
//   architectural model (pc, registers, halted) that predicts each EXEC
//   cycle's strobes and the resulting pc.
module tb_control_sequencer;
    import control_sequencer_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    control_sequencer_if #(.PC_W(16)) bus();

    control_sequencer #(
        .PC_W     (16),
        .RESET_PC (16'h0000)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Environment: instruction memory and register file driven by DUT strobes
    logic [15:0] mem [0:65535];
    logic [15:0] rf  [0:7];

    assign bus.instruction = mem[bus.pc];
    assign bus.reg_zero    = (rf[bus.rd_sel] == 16'h0000);

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) rf[i] <= 16'h0000;
        end else if (bus.reg_we) begin
            case (bus.wb_sel)
                2'b00: rf[bus.rd_sel] <= bus.alu_op ? rf[bus.rd_sel] - rf[bus.rs_sel]
                                                    : rf[bus.rd_sel] + rf[bus.rs_sel];
                2'b01: rf[bus.rd_sel] <= bus.imm;
                2'b10: rf[bus.rd_sel] <= rf[bus.rs_sel];
                default: ;
            endcase
        end
    end

    // Architectural reference model
    logic [15:0] mpc;
    logic [15:0] mrf [0:7];
    bit          mhalt;
    int          n_out;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] mk(input logic [2:0] op, input logic [2:0] rd, input logic [9:0] low);
        return {op, rd, low};
    endfunction

    task automatic fill_halt;
        for (int i = 0; i < 65536; i++) mem[i] = 16'h6000;
    endtask

    task automatic do_reset;
        reset         = 1'b1;
        bus.run       = 1'b0;
        bus.out_ready = 1'b0;
        tick;
        tick;
        chk("rst_pc", bus.pc, 16'h0000);
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_halted", bus.halted, 1'b0);
        chk("rst_reg_we", bus.reg_we, 1'b0);
        chk("rst_alu_op", bus.alu_op, 1'b0);
        chk("rst_wb_sel", bus.wb_sel, 2'b00);
        reset = 1'b0;
        mpc   = 16'h0000;
        mhalt = 1'b0;
        n_out = 0;
        for (int i = 0; i < 8; i++) mrf[i] = 16'h0000;
    endtask

    // Run one instruction: `pause` cycles with run low in FETCH, then fetch,
    // execute and (for out) hold out_ready low for `odly` OUT_WAIT cycles.
    task automatic exec_one(input int pause, input int odly);
        logic [15:0] w, imm;
        logic [2:0]  op, rd, rs;
        logic        we, alu;
        logic [1:0]  wb;
        if (mhalt) begin
            bus.run = 1'b1;
            tick;
            chk("halt_stays", bus.halted, 1'b1);
            chk("halt_pc", bus.pc, mpc);
            chk("halt_we", bus.reg_we, 1'b0);
            bus.run = 1'b0;
            return;
        end
        bus.run = 1'b0;
        for (int k = 0; k < pause; k++) begin
            tick;
            chk("pause_pc", bus.pc, mpc);
            chk("pause_we", bus.reg_we, 1'b0);
        end
        bus.run = 1'b1;
        chk("fetch_pc", bus.pc, mpc);
        chk("fetch_we", bus.reg_we, 1'b0);
        tick;
        bus.run = 1'b0;

        w   = mem[mpc];
        op  = w[15:13];
        rd  = w[12:10];
        rs  = w[9:7];
        imm = {{6{w[9]}}, w[9:0]};
        we  = 1'b0;
        alu = 1'b0;
        wb  = 2'b00;
        case (op)
            3'b000: we = 1'b1;
            3'b001: begin we = 1'b1; alu = 1'b1; end
            3'b101: begin we = 1'b1; wb = 2'b01; end
            3'b111: if (rd != 3'd0) begin we = 1'b1; wb = 2'b10; end
            default: ;
        endcase
        chk("exec_we", bus.reg_we, we);
        chk("exec_alu", bus.alu_op, alu);
        chk("exec_wb", bus.wb_sel, wb);
        chk("exec_rd", bus.rd_sel, rd);
        chk("exec_rs", bus.rs_sel, rs);
        chk("exec_imm", bus.imm, imm);
        chk("exec_pc", bus.pc, mpc);

        if (op == 3'b011) begin
            tick;
            chk("halt_set", bus.halted, 1'b1);
            chk("halt_pc", bus.pc, mpc);
            mhalt = 1'b1;
        end else if (op == 3'b100) begin
            tick;
            for (int k = 0; k <= odly; k++) begin
                bus.out_ready = (k == odly);
                chk("out_valid", bus.out_valid, 1'b1);
                chk("out_rd", bus.rd_sel, rd);
                chk("out_pc", bus.pc, mpc);
                if (k == odly) begin
                    chk("out_data", rf[bus.rd_sel], mrf[rd]);
                    n_out++;
                end
                tick;
            end
            bus.out_ready = 1'b0;
            mpc = mpc + 16'd1;
            chk("out_done", bus.out_valid, 1'b0);
            chk("out_post_pc", bus.pc, mpc);
        end else begin
            case (op)
                3'b000: begin mrf[rd] = mrf[rd] + mrf[rs]; mpc = mpc + 16'd1; end
                3'b001: begin mrf[rd] = mrf[rd] - mrf[rs]; mpc = mpc + 16'd1; end
                3'b101: begin mrf[rd] = imm;               mpc = mpc + 16'd1; end
                3'b110: mpc = (mrf[rd] == 16'd0) ? mpc + 16'd1 + imm : mpc + 16'd1;
                3'b111: begin
                    if (rd == 3'd0) mpc = mpc + imm;
                    else begin mrf[rd] = mrf[rs]; mpc = mpc + 16'd1; end
                end
                default: mpc = mpc + 16'd1;
            endcase
            tick;
            chk("post_pc", bus.pc, mpc);
            chk("post_halted", bus.halted, 1'b0);
        end
    endtask

    task automatic run_prog(input int max_instr, input bit rnd);
        for (int i = 0; i < max_instr && !mhalt; i++) begin
            if (rnd) exec_one($urandom_range(0, 2), $urandom_range(0, 3));
            else     exec_one(0, 0);
        end
        chk("halt_reached", bus.halted, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] rop, rrd, rrs;
        logic [9:0] rlow;
        reset         = 1'b1;
        bus.run       = 1'b0;
        bus.out_ready = 1'b0;

        // 1: ldi r0,#1 then halt
        fill_halt;
        mem[0] = mk(OP_LDI, 3'd0, 10'd1);
        do_reset;
        exec_one(0, 0);
        exec_one(0, 0);
        chk("t1_pc", bus.pc, 16'h0001);
        chk("t1_halted", bus.halted, 1'b1);
        chk("t1_r0", rf[0], 16'h0001);
        for (int i = 0; i < 3; i++) exec_one(0, 0);

        // 2: countdown 10..0 on the OUT port
        fill_halt;
        mem[0] = mk(OP_LDI, 3'd0, 10'd10);
        mem[1] = mk(OP_LDI, 3'd1, 10'd1);
        mem[2] = mk(OP_OUT, 3'd0, 10'd0);
        mem[3] = mk(OP_BNE, 3'd0, 10'd2);
        mem[4] = mk(OP_SUB, 3'd0, {3'd1, 7'd0});
        mem[5] = mk(OP_JMP, 3'd0, 10'h3FD);
        mem[6] = 16'h6000;
        do_reset;
        bus.out_ready = 1'b1;
        run_prog(100, 1'b0);
        chk("t2_transfers", n_out, 11);
        chk("t2_pc", bus.pc, 16'h0006);

        // 3: out with 5 cycles of backpressure
        fill_halt;
        mem[0] = mk(OP_LDI, 3'd2, 10'h055);
        mem[1] = mk(OP_OUT, 3'd2, 10'd0);
        do_reset;
        exec_one(0, 0);
        exec_one(0, 5);
        chk("t3_pc", bus.pc, 16'h0002);

        // 4: jmp wrap and bne taken / not taken
        fill_halt;
        mem[16'h0000] = mk(OP_JMP, 3'd0, 10'h3FF);
        mem[16'hFFFF] = mk(OP_JMP, 3'd0, 10'd5);
        mem[16'h0004] = mk(OP_BNE, 3'd2, 10'd1);
        mem[16'h0006] = mk(OP_LDI, 3'd2, 10'd7);
        mem[16'h0007] = mk(OP_JMP, 3'd0, 10'h3FD);
        do_reset;
        exec_one(0, 0); chk("t4_wrap_down", bus.pc, 16'hFFFF);
        exec_one(0, 0); chk("t4_wrap_up", bus.pc, 16'h0004);
        exec_one(0, 0); chk("t4_bne_taken", bus.pc, 16'h0006);
        exec_one(0, 0);
        exec_one(0, 0); chk("t4_jmp_back", bus.pc, 16'h0004);
        exec_one(0, 0); chk("t4_bne_fall", bus.pc, 16'h0005);

        // 5: reset while waiting in OUT_WAIT
        fill_halt;
        mem[0] = mk(OP_LDI, 3'd1, 10'd5);
        mem[1] = mk(OP_OUT, 3'd1, 10'd0);
        do_reset;
        exec_one(0, 0);
        bus.run = 1'b1;
        tick;
        bus.run = 1'b0;
        tick;
        chk("t5_waiting", bus.out_valid, 1'b1);
        reset = 1'b1;
        tick;
        chk("t5_valid_drop", bus.out_valid, 1'b0);
        chk("t5_pc", bus.pc, 16'h0000);
        chk("t5_halted", bus.halted, 1'b0);
        reset = 1'b0;
        mpc   = 16'h0000;
        mhalt = 1'b0;
        for (int i = 0; i < 8; i++) mrf[i] = 16'h0000;
        exec_one(0, 0);
        chk("t5_refetch_pc", bus.pc, 16'h0001);

        // 6: pause in FETCH, undefined opcode behaves as NOP
        fill_halt;
        mem[0] = mk(OP_LDI, 3'd1, 10'd3);
        mem[1] = mk(OP_UND, 3'd5, 10'h2AB);
        do_reset;
        exec_one(3, 0);
        exec_one(0, 0);
        chk("t6_pc", bus.pc, 16'h0002);
        chk("t6_r5", rf[5], 16'h0000);

        // Randomised forward-only programs ending in halt padding
        for (int r = 0; r < 4; r++) begin
            fill_halt;
            for (int a = 0; a < 32; a++) begin
                rrd  = 3'($urandom_range(0, 7));
                rrs  = 3'($urandom_range(0, 7));
                rlow = 10'($urandom);
                case ($urandom_range(0, 7))
                    0: rop = OP_ADD;
                    1: rop = OP_SUB;
                    2: rop = OP_UND;
                    3: rop = OP_LDI;
                    4: rop = OP_OUT;
                    5: begin rop = OP_BNE; rlow = 10'($urandom_range(0, 3)); end
                    6: begin rop = OP_JMP; rrd = 3'd0; rlow = 10'($urandom_range(1, 3)); end
                    default: begin rop = OP_JMP; rrd = 3'($urandom_range(1, 7)); end
                endcase
                if (rop == OP_ADD || rop == OP_SUB || (rop == OP_JMP && rrd != 3'd0))
                    rlow = {rrs, rlow[6:0]};
                mem[a] = mk(rop, rrd, rlow);
            end
            do_reset;
            run_prog(60, 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
